// File: rtl/outlogic_pkg.sv
// Shared types and segment constants for the board output stage.
package outlogic_pkg;

  typedef enum logic {SHOW, PEEK} disp_state_t;

  localparam int unsigned DATA_W = 10;
  localparam int unsigned SEG_W  = 7;

  localparam logic [SEG_W-1:0] SEG_P    = 7'b0001100;
  localparam logic [SEG_W-1:0] SEG_ZERO = 7'b1000000;

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex digit to active-low seven-segment decoder, segments {g,f,e,d,c,b,a}.
module hex_to_7seg
  import outlogic_pkg::*;
(
  input  logic [3:0]       value,
  output logic [SEG_W-1:0] seg
);

  always_comb begin
    seg = SEG_ZERO;
    case (value)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = SEG_ZERO;
    endcase
  end

endmodule

// File: rtl/output_logic.sv
// Processor result register, LED/hex display drive and timed peek view of a selected register.
module output_logic
  import outlogic_pkg::*;
#(
  parameter int unsigned PEEK_HOLD_CYCLES = 50_000_000
) (
  input  logic              CLK_50MHz,
  input  logic              Reset,
  input  logic [DATA_W-1:0] databus,
  input  logic              LED_B,
  input  logic              PeeKb,
  input  logic [DATA_W-1:0] Peek_data,
  input  logic [1:0]        Timestep,
  input  logic              Done,
  output logic [DATA_W-1:0] LEDs,
  output logic [SEG_W-1:0]  HEX0,
  output logic [SEG_W-1:0]  HEX1,
  output logic [SEG_W-1:0]  HEX2,
  output logic [SEG_W-1:0]  HEX3,
  output logic              Peek_active,
  output logic              Done_LED
);

  localparam int unsigned CNT_W = $clog2(PEEK_HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(PEEK_HOLD_CYCLES - 1);

  disp_state_t       state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              pk_prev;
  logic              peek_rise;
  logic [DATA_W-1:0] disp_val;
  logic [SEG_W-1:0]  seg0, seg1, seg2, seg_ts;

  assign peek_rise = PeeKb & ~pk_prev;

  // State, hold counter and peek-key history
  always_ff @(posedge CLK_50MHz) begin
    if (Reset) begin
      state       <= SHOW;
      cnt         <= '0;
      pk_prev     <= 1'b0;
      Peek_active <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      pk_prev     <= PeeKb;
      Peek_active <= (state_n == PEEK);
    end
  end

  // Next state: a new rise always restarts the hold, even on the expiry cycle
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      SHOW: begin
        if (peek_rise) begin
          state_n = PEEK;
          cnt_n   = HOLD_RELOAD;
        end
      end
      PEEK: begin
        if (peek_rise) begin
          cnt_n = HOLD_RELOAD;
        end else if (cnt == '0) begin
          state_n = SHOW;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_n = SHOW;
        cnt_n   = '0;
      end
    endcase
  end

  assign disp_val = (state == PEEK) ? Peek_data : LEDs;

  hex_to_7seg u_hex0 (.value(disp_val[3:0]),         .seg(seg0));
  hex_to_7seg u_hex1 (.value(disp_val[7:4]),         .seg(seg1));
  hex_to_7seg u_hex2 (.value({2'b00, disp_val[9:8]}), .seg(seg2));
  hex_to_7seg u_hex3 (.value({2'b00, Timestep}),      .seg(seg_ts));

  // Result register, registered digits and done indicator
  always_ff @(posedge CLK_50MHz) begin
    if (Reset) begin
      LEDs     <= '0;
      HEX0     <= SEG_ZERO;
      HEX1     <= SEG_ZERO;
      HEX2     <= SEG_ZERO;
      HEX3     <= SEG_ZERO;
      Done_LED <= 1'b0;
    end else begin
      if (LED_B) begin
        LEDs <= databus;
      end
      HEX0     <= seg0;
      HEX1     <= seg1;
      HEX2     <= seg2;
      HEX3     <= (state == PEEK) ? SEG_P : seg_ts;
      Done_LED <= Done;
    end
  end

endmodule
